intra_tu_dispatch: RTL and testbench

Sequences the transform units of one CTB into per-component intra prediction commands. Buffers TU descriptors from the CTU parser in a small FIFO and latches the CTB origin. For each TU it issues one luma command and, when due, Cb and Cr commands over a valid/ready handshake. Its outputs drive the coordinate-transform stage (luma and chroma instances) directly upstream of the intra predictor.

---
 rtl/intra_tu_dispatch.sv | 153 +++++++++++++++
 tb/tb_intra_tu_dispatch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra_tu_dispatch.sv
// Intra TU dispatcher: buffers TU descriptors for one CTB and issues
// per-component intra prediction commands over a valid/ready handshake.
module intra_tu_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter bit CHROMA_EN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ctb_start,
  input  logic [8:0] i_xCtb,
  input  logic [8:0] i_yCtb,
  input  logic       tu_valid,
  output logic       tu_ready,
  input  logic [3:0] tu_xRela,
  input  logic [3:0] tu_yRela,
  input  logic [2:0] tu_size,
  input  logic       tu_last,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [8:0] o_xCtb,
  output logic [8:0] o_yCtb,
  output logic [3:0] o_xTb_rela,
  output logic [3:0] o_yTb_rela,
  output logic [2:0] o_tuSize,
  output logic [1:0] o_cIdx,
  output logic       o_last,
  output logic       o_ctbDone,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] size;
    logic       last;
  } tu_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, Y, CB, CR
  } state_t;

  state_t        state, stateNext;
  tu_t           mem [FIFO_DEPTH];
  tu_t           cur;
  tu_t           head;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0]   count;
  logic          full, push, pop, hs;

  // Only the 4th 4x4 of a quad carries the shared 4x4 chroma block
  function automatic logic chromaDue(input tu_t t);
    return CHROMA_EN &&
      (t.size != 3'd2 || (t.x[0] && t.y[0]));
  endfunction

  assign full     = (count == FULL_CNT);
  assign tu_ready = !full;
  assign push     = tu_valid && !full;
  assign head     = mem[rdPtr];
  assign hs       = o_valid && o_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push)
      mem[wrPtr] <= '{tu_xRela, tu_yRela, tu_size, tu_last};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: if (ctb_start) stateNext = LOAD;
      LOAD: begin
        if (count != '0) begin
          pop       = 1'b1;
          stateNext = Y;
        end
      end
      Y: begin
        if (hs) begin
          if (chromaDue(cur)) stateNext = CB;
          else if (cur.last)  stateNext = IDLE;
          else                stateNext = LOAD;
        end
      end
      CB: if (hs) stateNext = CR;
      CR: if (hs) stateNext = cur.last ? IDLE : LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur        <= '0;
      o_valid    <= 1'b0;
      o_xCtb     <= '0;
      o_yCtb     <= '0;
      o_xTb_rela <= '0;
      o_yTb_rela <= '0;
      o_tuSize   <= '0;
      o_cIdx     <= '0;
      o_last     <= 1'b0;
      o_ctbDone  <= 1'b0;
    end else begin
      o_ctbDone <= hs && o_last;
      if (state == IDLE && ctb_start) begin
        o_xCtb <= i_xCtb;
        o_yCtb <= i_yCtb;
      end
      if (pop) begin
        cur        <= head;
        o_valid    <= 1'b1;
        o_xTb_rela <= head.x;
        o_yTb_rela <= head.y;
        o_tuSize   <= head.size;
        o_cIdx     <= 2'd0;
        o_last     <= head.last && !chromaDue(head);
      end else if (hs) begin
        if (state == Y && chromaDue(cur)) begin
          o_cIdx <= 2'd1;
          o_last <= 1'b0;
        end else if (state == CB) begin
          o_cIdx <= 2'd2;
          o_last <= cur.last;
        end else begin
          o_valid <= 1'b0;
          o_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_intra_tu_dispatch.sv
// Directed bench for intra_tu_dispatch: expected command stream is
// expanded from the pushed TU list and checked at every handshake.
module tb_intra_tu_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ctb_start;
  logic [8:0] i_xCtb, i_yCtb;
  logic       tu_valid, tu_ready;
  logic [3:0] tu_xRela, tu_yRela;
  logic [2:0] tu_size;
  logic       tu_last;
  logic       o_valid, o_ready;
  logic [8:0] o_xCtb, o_yCtb;
  logic [3:0] o_xTb_rela, o_yTb_rela;
  logic [2:0] o_tuSize;
  logic [1:0] o_cIdx;
  logic       o_last, o_ctbDone, busy;

  always #5 clk = ~clk;

  intra_tu_dispatch #(.FIFO_DEPTH(4), .CHROMA_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ctb_start(ctb_start),
    .i_xCtb(i_xCtb), .i_yCtb(i_yCtb),
    .tu_valid(tu_valid), .tu_ready(tu_ready),
    .tu_xRela(tu_xRela), .tu_yRela(tu_yRela),
    .tu_size(tu_size), .tu_last(tu_last),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_xCtb(o_xCtb), .o_yCtb(o_yCtb),
    .o_xTb_rela(o_xTb_rela), .o_yTb_rela(o_yTb_rela),
    .o_tuSize(o_tuSize), .o_cIdx(o_cIdx),
    .o_last(o_last), .o_ctbDone(o_ctbDone), .busy(busy)
  );

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] size;
    logic [1:0] cidx;
    logic       last;
  } cmd_t;

  int   checks = 0;
  int   failures = 0;
  cmd_t expQ[$];
  logic [8:0] expX = '0, expY = '0;

  function automatic void chk(string name, logic [31:0] act,
                              logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference: Y, then Cb/Cr when the TU owns chroma; last on final one
  function automatic void modelTu(logic [3:0] x, logic [3:0] y,
                                  logic [2:0] s, logic last);
    logic due;
    due = (s != 3'd2) || (x[0] && y[0]);
    expQ.push_back('{x, y, s, 2'd0, last && !due});
    if (due) begin
      expQ.push_back('{x, y, s, 2'd1, 1'b0});
      expQ.push_back('{x, y, s, 2'd2, last});
    end
  endfunction

  logic hold = 1'b0;
  logic doneExp = 1'b0;
  int   hsCount = 0;
  logic [13:0] held;
  cmd_t e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold    = 1'b0;
      doneExp = 1'b0;
    end else begin
      chk("ctbDone", o_ctbDone, doneExp);
      doneExp = 1'b0;
      if (hold) begin
        chk("stable_valid", o_valid, 1);
        chk("stable_data", {o_xTb_rela, o_yTb_rela, o_tuSize,
                            o_cIdx, o_last}, held);
      end
      if (o_valid && o_ready) begin
        hsCount++;
        hold = 1'b0;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_cmd actual=%0h required=none",
                   {o_xTb_rela, o_yTb_rela, o_cIdx});
        end else begin
          e = expQ.pop_front();
          chk("cmd", {o_xCtb, o_yCtb, o_xTb_rela, o_yTb_rela,
                      o_tuSize, o_cIdx, o_last},
              {expX, expY, e.x, e.y, e.size, e.cidx, e.last});
          doneExp = e.last;
        end
      end else if (o_valid) begin
        hold = 1'b1;
        held = {o_xTb_rela, o_yTb_rela, o_tuSize, o_cIdx, o_last};
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushTu(logic [3:0] x, logic [3:0] y, logic [2:0] s,
                        logic last, logic acc);
    tu_valid = 1'b1;
    tu_xRela = x;
    tu_yRela = y;
    tu_size  = s;
    tu_last  = last;
    @(negedge clk);
    chk("tu_ready", tu_ready, acc);
    if (acc) modelTu(x, y, s, last);
    tick();
    tu_valid = 1'b0;
  endtask

  task automatic startCtb(logic [8:0] x, logic [8:0] y);
    ctb_start = 1'b1;
    i_xCtb    = x;
    i_yCtb    = y;
    expX      = x;
    expY      = y;
    tick();
    ctb_start = 1'b0;
  endtask

  task automatic waitIdle(int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL wait_idle actual=busy required=idle");
    end
    tick();
  endtask

  int base;

  initial begin
    rst_n = 1'b0;
    ctb_start = 1'b0;
    i_xCtb = '0;
    i_yCtb = '0;
    tu_valid = 1'b0;
    tu_xRela = '0;
    tu_yRela = '0;
    tu_size = '0;
    tu_last = 1'b0;
    o_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tu_ready, 1);
    chk("rst_data", {o_xCtb, o_cIdx, o_last, o_ctbDone}, 0);
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    chk("idle_valid", o_valid, 0);

    // one 8x8 TU with literal timing
    pushTu(4'd2, 4'd4, 3'd3, 1'b1, 1'b1);
    startCtb(9'd5, 9'd7);
    chk("load_busy", busy, 1);
    chk("load_valid", o_valid, 0);
    tick();
    chk("y_cmd", {o_valid, o_xCtb, o_yCtb, o_xTb_rela, o_yTb_rela,
                  o_tuSize, o_cIdx, o_last},
        {1'b1, 9'd5, 9'd7, 4'd2, 4'd4, 3'd3, 2'd0, 1'b0});
    tick();
    chk("cb_cmd", {o_valid, o_cIdx, o_last}, {1'b1, 2'd1, 1'b0});
    tick();
    chk("cr_cmd", {o_valid, o_cIdx, o_last}, {1'b1, 2'd2, 1'b1});
    tick();
    chk("done_pulse", {o_ctbDone, o_valid, busy}, 3'b100);
    tick();
    chk("done_clear", o_ctbDone, 0);

    // four 4x4 TUs; stray ctb_start while busy is ignored
    pushTu(4'd0, 4'd0, 3'd2, 1'b0, 1'b1);
    pushTu(4'd1, 4'd0, 3'd2, 1'b0, 1'b1);
    pushTu(4'd0, 4'd1, 3'd2, 1'b0, 1'b1);
    pushTu(4'd1, 4'd1, 3'd2, 1'b1, 1'b1);
    base = hsCount;
    startCtb(9'd1, 9'd2);
    tick();
    ctb_start = 1'b1;
    i_xCtb = 9'd300;
    i_yCtb = 9'd301;
    tick();
    ctb_start = 1'b0;
    waitIdle(60);
    chk("quad_cmds", hsCount - base, 6);

    // backpressure during Cb
    pushTu(4'd3, 4'd5, 3'd4, 1'b1, 1'b1);
    startCtb(9'd2, 9'd3);
    tick();
    tick();
    o_ready = 1'b0;
    chk("bp_cb", {o_valid, o_cIdx}, {1'b1, 2'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {o_valid, o_cIdx, busy}, {1'b1, 2'd1, 1'b1});
    end
    o_ready = 1'b1;
    tick();
    chk("bp_cr", {o_valid, o_cIdx, o_last}, {1'b1, 2'd2, 1'b1});
    waitIdle(10);

    // FIFO full, odd size passthrough, order preserved
    pushTu(4'd1, 4'd2, 3'd6, 1'b0, 1'b1);
    pushTu(4'd3, 4'd3, 3'd2, 1'b0, 1'b1);
    pushTu(4'd2, 4'd3, 3'd2, 1'b0, 1'b1);
    pushTu(4'd5, 4'd6, 3'd3, 1'b1, 1'b1);
    chk("full_ready", tu_ready, 0);
    pushTu(4'd7, 4'd7, 3'd3, 1'b0, 1'b0);
    startCtb(9'd9, 9'd1);
    tick();
    chk("pop_ready", tu_ready, 1);
    waitIdle(60);

    // async reset during Cb of the 2nd TU
    pushTu(4'd4, 4'd0, 3'd3, 1'b0, 1'b1);
    pushTu(4'd8, 4'd0, 3'd3, 1'b1, 1'b1);
    pushTu(4'd9, 4'd9, 3'd4, 1'b1, 1'b1);
    startCtb(9'd11, 9'd12);
    repeat (6) tick();
    chk("pre_rst", {o_valid, o_xTb_rela, o_cIdx},
        {1'b1, 4'd8, 2'd1});
    rst_n = 1'b0;
    expQ.delete();
    #1;
    chk("mid_rst", {o_valid, busy, o_cIdx, o_last, o_xCtb,
                    o_xTb_rela}, 0);
    chk("mid_rst_ready", tu_ready, 1);
    tick();
    rst_n = 1'b1;
    startCtb(9'd4, 9'd4);
    repeat (3) tick();
    chk("empty_after_rst", {o_valid, busy}, 2'b01);
    pushTu(4'd6, 4'd2, 3'd5, 1'b1, 1'b1);
    waitIdle(20);

    repeat (3) tick();
    chk("queue_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
